// File: rtl/ifetch_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ifetch_mem_arbiter
//
// Shares one 64-bit memory port between the instruction prefetch refill
// (if_*) and the load/store unit (d_*). Only one memory transaction is in
// flight at a time. Data normally wins contention. After MAX_DATA_STREAK
// consecutive data grants while a fetch is waiting, the fetch is forced
// through. A redirect (if_flush) during a fetch discards that fetch's return.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   if_req/if_addr       fetch request (held until if_gnt), 64-bit aligned
//   if_flush             redirect: kill the outstanding fetch return
//   if_gnt/if_valid      one-cycle pulses: fetch accepted / if_rdata valid
//   if_rdata             fetch data
//   d_req/d_we/d_addr    data request (held until d_gnt), write flag, address
//   d_wdata/d_be         write data and byte enables
//   d_gnt/d_valid        one-cycle pulses: data accepted / access complete
//   d_rdata              read data (0 after a write)
//   mem_req..mem_be      memory request, held until mem_ready
//   mem_rdata/mem_ready  memory read data, qualified by mem_ready
//   bus_err              one-cycle pulse on a timeout abort
//
// Build option
//   ARB_TIMEOUT_EN  when defined, a busy transaction that sees no mem_ready
//                   for TIMEOUT_CYCLES cycles is aborted with bus_err.
//                   Otherwise bus_err is tied low and the wait is unbounded.
// ---------------------------------------------------------------------------
module ifetch_mem_arbiter #(
    parameter int ADDR_W          = 25,
    parameter int MAX_DATA_STREAK = 3,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [63:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    input  logic [7:0]        d_be,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [63:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_be,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, FETCH_BUSY, DATA_BUSY} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_bad_streak
        $error("MAX_DATA_STREAK must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..1023");
    end

    state_t      state;
    logic [3:0]  streak;         // data grants issued while fetch was waiting
    logic        flush_pending;  // current fetch return must be dropped
    logic        fetch_wins;
    logic        kill_fetch;
    logic        finish;         // busy transaction ends at this edge
    logic [63:0] ret_data;

    assign fetch_wins = if_req && (!d_req || streak == STREAK_MAX);
    // A flush in the completion cycle itself must also suppress the return.
    assign kill_fetch = flush_pending || if_flush;

`ifdef ARB_TIMEOUT_EN
    localparam logic [9:0] BUSY_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [9:0] busy_cnt;
    logic       timed_out;

    assign timed_out = (busy_cnt == BUSY_LAST);
    // mem_ready on the limit cycle is a normal completion, never an error.
    assign finish    = mem_ready || timed_out;
    assign ret_data  = mem_ready ? mem_rdata : 64'd0;
`else
    assign finish    = mem_ready;
    assign ret_data  = mem_rdata;
    assign bus_err   = 1'b0;
`endif

    // NOTE: state is updated only with non-blocking assignments so every
    // read in this block sees the value from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            streak        <= '0;
            flush_pending <= 1'b0;
            if_gnt        <= 1'b0;
            if_valid      <= 1'b0;
            if_rdata      <= '0;
            d_gnt         <= 1'b0;
            d_valid       <= 1'b0;
            d_rdata       <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
`ifdef ARB_TIMEOUT_EN
            busy_cnt      <= '0;
            bus_err       <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low here; the case below raises
            // them for exactly one cycle.
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            if (!if_req) streak <= '0;

            case (state)
                IDLE: begin
                    flush_pending <= 1'b0;
                    if (fetch_wins) begin
                        if_gnt    <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= 8'hFF;
                        streak    <= '0;
                        state     <= FETCH_BUSY;
                    end else if (d_req) begin
                        d_gnt     <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        if (if_req && streak != STREAK_MAX) streak <= streak + 4'd1;
                        state     <= DATA_BUSY;
                    end
                end
                FETCH_BUSY: begin
                    if (if_flush) flush_pending <= 1'b1;
                    if (finish) begin
                        mem_req       <= 1'b0;
                        flush_pending <= 1'b0;
                        state         <= IDLE;
                        if (!kill_fetch) begin
                            if_valid <= 1'b1;
                            if_rdata <= ret_data;
                        end
                    end
                end
                DATA_BUSY: begin
                    if (finish) begin
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        d_rdata <= mem_we ? 64'd0 : ret_data;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef ARB_TIMEOUT_EN
            bus_err <= 1'b0;
            if (state == IDLE) begin
                busy_cnt <= '0;
            end else if (!mem_ready) begin
                if (timed_out) bus_err  <= 1'b1;
                else           busy_cnt <= busy_cnt + 10'd1;
            end
`endif
        end
    end

endmodule
